risc_controller: RTL and testbench

Instruction-sequencing controller for the 8-bit RISC CPU, issuing the control strobes that drive the program counter, instruction register, memory, accumulator and ALU. It decodes the 3-bit opcode held in the instruction register, the same encoding the ALU consumes, through a fixed 8-phase cycle per instruction. It uses the ALU zero flag for conditional skip and latches a halt state on HLT. It sits between the instruction register/ALU and the datapath load and enable controls.

---
 rtl/risc_pkg.sv | 42 ++++
 rtl/risc_ctrl_decode.sv | 55 +++++
 rtl/risc_controller.sv | 86 ++++++++
 tb/tb_risc_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared ISA definitions for the 8-bit RISC CPU: opcodes, controller phases and
// the bundle of datapath control strobes.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic halt;
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic data_e;
    logic wr;
  } ctrl_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Purely combinational decode of phase, opcode, zero flag and halt state into
// the datapath control strobes.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  phase_e      phase,
  input  logic [2:0]  opcode,
  input  logic        is_zero,
  input  logic        halted,
  output ctrl_t       ctrl
);

  logic aluop;

  always_comb begin
    ctrl  = '0;
    aluop = is_aluop(opcode);
    if (halted) begin
      ctrl.halt = 1'b1;
    end else begin
      unique case (phase)
        PH_INST_ADDR: ctrl.sel = 1'b1;
        PH_INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: ctrl.rd = aluop;
        PH_ALU_OP: begin
          ctrl.rd     = aluop;
          ctrl.inc_pc = (opcode == OP_SKZ) && is_zero;
          ctrl.ld_pc  = (opcode == OP_JMP);
          ctrl.data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          ctrl.rd     = aluop;
          ctrl.ld_ac  = aluop;
          ctrl.ld_pc  = (opcode == OP_JMP);
          ctrl.wr     = (opcode == OP_STO);
          ctrl.data_e = (opcode == OP_STO);
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer for the RISC CPU with a latched halt state.
// Define RISC_CTRL_STEP_EN to add a `step` input gating the advance out of phase 0.
module risc_controller
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
`ifdef RISC_CTRL_STEP_EN
  input  logic       step,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   advance;
  ctrl_t  ctrl, ctrl_out;

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    advance  = 1'b0;
    if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
        // Phase freezes at OP_ADDR for the lifetime of the halt.
        halted_d = 1'b1;
      end else begin
        advance = 1'b1;
`ifdef RISC_CTRL_STEP_EN
        if (phase_q == PH_INST_ADDR && !step) begin
          advance = 1'b0;
        end
`endif
      end
    end
    if (advance) begin
      phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  risc_ctrl_decode u_decode (
    .phase   (phase_q),
    .opcode  (opcode),
    .is_zero (is_zero),
    .halted  (halted_q),
    .ctrl    (ctrl)
  );

  // Reset masks every strobe immediately, so an aborted STO never writes.
  always_comb begin
    ctrl_out = rst ? '0 : ctrl;
    phase    = rst ? 3'd0 : phase_q;
  end

  assign sel    = ctrl_out.sel;
  assign rd     = ctrl_out.rd;
  assign ld_ir  = ctrl_out.ld_ir;
  assign inc_pc = ctrl_out.inc_pc;
  assign ld_pc  = ctrl_out.ld_pc;
  assign ld_ac  = ctrl_out.ld_ac;
  assign data_e = ctrl_out.data_e;
  assign wr     = ctrl_out.wr;
  assign halt   = ctrl_out.halt;

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_risc_controller;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       step;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;

  typedef struct {
    logic [2:0] ph;
    logic [8:0] bits;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bit order: halt sel rd ld_ir inc_pc ld_pc ld_ac data_e wr
  localparam logic [8:0] B_NONE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] B_PH0   = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] B_PH1   = 9'b0_1_1_0_0_0_0_0_0;
  localparam logic [8:0] B_PH23  = 9'b0_1_1_1_0_0_0_0_0;
  localparam logic [8:0] B_INC   = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] B_RD    = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] B_RDAC  = 9'b0_0_1_0_0_0_1_0_0;
  localparam logic [8:0] B_DE    = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] B_DEWR  = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [8:0] B_LDPC  = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] B_HLT4  = 9'b1_0_0_0_1_0_0_0_0;
  localparam logic [8:0] B_HALT  = 9'b1_0_0_0_0_0_0_0_0;

  always #5 clk = ~clk;

  risc_controller dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .is_zero (is_zero),
`ifdef RISC_CTRL_STEP_EN
    .step    (step),
`endif
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .ld_ac   (ld_ac),
    .data_e  (data_e),
    .wr      (wr),
    .halt    (halt),
    .phase   (phase)
  );

  // Monitor: outputs are presented every cycle; compare whenever an expectation waits.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr};
      n_cmp++;
      if (act !== e.bits || phase !== e.ph) begin
        n_bad++;
        $display("FAIL %s: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
                 e.name, phase, act, e.ph, e.bits);
      end
    end
  end

  // Drive one cycle of inputs (just after the edge) and queue the expected outputs.
  task automatic cyc(input logic r, input logic [2:0] op, input logic z,
                     input logic [2:0] ph, input logic [8:0] bits, input string name);
    exp_t e;
    rst     = r;
    opcode  = op;
    is_zero = z;
    e.ph    = ph;
    e.bits  = bits;
    e.name  = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [2:0] op, input string name);
    cyc(1'b0, op, 1'b0, 3'd0, B_PH0,  {name, "_ph0"});
    cyc(1'b0, op, 1'b0, 3'd1, B_PH1,  {name, "_ph1"});
    cyc(1'b0, op, 1'b0, 3'd2, B_PH23, {name, "_ph2"});
    cyc(1'b0, op, 1'b0, 3'd3, B_PH23, {name, "_ph3"});
  endtask

  initial begin
    rst     = 1'b1;
    opcode  = OP_ADD;
    is_zero = 1'b0;
    step    = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, OP_ADD, 1'b0, 3'd0, B_NONE, "reset0");
    cyc(1'b1, OP_ADD, 1'b0, 3'd0, B_NONE, "reset1");

    fetch(OP_ADD, "add");
    cyc(1'b0, OP_ADD, 1'b0, 3'd4, B_INC,  "add_ph4");
    cyc(1'b0, OP_ADD, 1'b0, 3'd5, B_RD,   "add_ph5");
    cyc(1'b0, OP_ADD, 1'b0, 3'd6, B_RD,   "add_ph6");
    cyc(1'b0, OP_ADD, 1'b0, 3'd7, B_RDAC, "add_ph7");

    fetch(OP_STO, "sto");
    cyc(1'b0, OP_STO, 1'b0, 3'd4, B_INC,  "sto_ph4");
    cyc(1'b0, OP_STO, 1'b0, 3'd5, B_NONE, "sto_ph5");
    cyc(1'b0, OP_STO, 1'b0, 3'd6, B_DE,   "sto_ph6");
    cyc(1'b0, OP_STO, 1'b0, 3'd7, B_DEWR, "sto_ph7");

    fetch(OP_SKZ, "skz1");
    cyc(1'b0, OP_SKZ, 1'b1, 3'd4, B_INC,  "skz1_ph4");
    cyc(1'b0, OP_SKZ, 1'b1, 3'd5, B_NONE, "skz1_ph5");
    cyc(1'b0, OP_SKZ, 1'b1, 3'd6, B_INC,  "skz1_ph6");
    cyc(1'b0, OP_SKZ, 1'b1, 3'd7, B_NONE, "skz1_ph7");

    fetch(OP_SKZ, "skz0");
    cyc(1'b0, OP_SKZ, 1'b0, 3'd4, B_INC,  "skz0_ph4");
    cyc(1'b0, OP_SKZ, 1'b0, 3'd5, B_NONE, "skz0_ph5");
    cyc(1'b0, OP_SKZ, 1'b0, 3'd6, B_NONE, "skz0_ph6");
    cyc(1'b0, OP_SKZ, 1'b0, 3'd7, B_NONE, "skz0_ph7");

    fetch(OP_JMP, "jmp");
    cyc(1'b0, OP_JMP, 1'b0, 3'd4, B_INC,  "jmp_ph4");
    cyc(1'b0, OP_JMP, 1'b0, 3'd5, B_NONE, "jmp_ph5");
    cyc(1'b0, OP_JMP, 1'b0, 3'd6, B_LDPC, "jmp_ph6");
    cyc(1'b1, OP_JMP, 1'b0, 3'd0, B_NONE, "jmp_rst");

    fetch(OP_HLT, "hlt");
    cyc(1'b0, OP_HLT, 1'b0, 3'd4, B_HLT4, "hlt_ph4");
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, OP_HLT, 1'b0, 3'd4, B_HALT, $sformatf("halted_%0d", i));
    end
    cyc(1'b1, OP_HLT, 1'b0, 3'd0, B_NONE, "hlt_rst");
    cyc(1'b0, OP_ADD, 1'b0, 3'd0, B_PH0,  "post_hlt_ph0");
    cyc(1'b0, OP_ADD, 1'b0, 3'd1, B_PH1,  "post_hlt_ph1");

`ifdef RISC_CTRL_STEP_EN
    cyc(1'b1, OP_ADD, 1'b0, 3'd0, B_NONE, "step_rst");
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, OP_ADD, 1'b0, 3'd0, B_PH0, $sformatf("step_hold_%0d", i));
    end
    step = 1'b1;
    cyc(1'b0, OP_ADD, 1'b0, 3'd0, B_PH0, "step_pulse");
    step = 1'b0;
    cyc(1'b0, OP_ADD, 1'b0, 3'd1, B_PH1,  "step_ph1");
    cyc(1'b0, OP_ADD, 1'b0, 3'd2, B_PH23, "step_ph2");
`endif

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
